// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared constants and boot image for the instruction fetch memory
package inst_mem_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;
    localparam int BOOT_WORDS = 6;

    // Boot image word lookup; words past the image read as zero
    function automatic logic [INSTR_W-1:0] boot_word(input int idx);
        case (idx)
            0:       return 32'h00940333;
            1:       return 32'h412983b3;
            2:       return 32'h00f768b3;
            3:       return 32'h00d67fb3;
            4:       return 32'h017b4e33;
            5:       return 32'h01bdaf33;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/inst_mem_bank.sv
// rtl/inst_mem_bank.sv - word storage with byte-strobe write and read-first registered read (INST_FETCH_MEM_BOOTROM_EN)
module inst_mem_bank
    import inst_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [INSTR_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [3:0]         wr_strb
);

    logic [INSTR_W-1:0] mem [DEPTH_WORDS];

    // Registered read; samples the array before any same-edge write lands
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= NOP_INSTR;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

`ifdef INST_FETCH_MEM_BOOTROM_EN
    // Reset reloads the boot image; otherwise apply strobed byte writes
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= boot_word(i);
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end
`else
    // Contents come only from strobed byte writes; the caller masks writes during reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end
`endif

endmodule

// File: rtl/inst_fetch_mem.sv
// rtl/inst_fetch_mem.sv - instruction fetch memory: request/response handshake, fault checks, program-load port (INST_FETCH_MEM_BOOTROM_EN)
module inst_fetch_mem
    import inst_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic               rsp_fault,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [3:0]         wr_strb
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // One extra bit so the range compare never wraps
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(4 * DEPTH_WORDS);

    logic               rsp_valid_q;
    logic               rsp_fault_q;
    logic               accept;
    logic               req_fault;
    logic               wr_ok;
    logic [INSTR_W-1:0] bank_rdata;

    assign req_fault = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= MEM_BYTES);
    assign req_ready = !reset && !flush && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign wr_ok     = wr_en && !reset && (wr_addr[1:0] == 2'b00) && ({1'b0, wr_addr} < MEM_BYTES);

    inst_mem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (accept && !req_fault),
        .rd_idx  (req_addr[IDX_W+1:2]),
        .rd_data (bank_rdata),
        .wr_en   (wr_ok),
        .wr_idx  (wr_addr[IDX_W+1:2]),
        .wr_data (wr_data),
        .wr_strb (wr_strb)
    );

    // Response slot: flush drops it, accept loads it, consumer handshake frees it
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
        end else if (flush) begin
            rsp_valid_q <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= req_fault;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Reset forces idle outputs immediately; faulted fetches present a NOP
    assign rsp_valid = rsp_valid_q && !reset;
    assign rsp_fault = rsp_fault_q && !reset;
    assign rsp_instr = (reset || rsp_fault_q) ? NOP_INSTR : bank_rdata;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// tb/tb_inst_fetch_mem.sv - randomized and directed self-checking bench for inst_fetch_mem
module tb_inst_fetch_mem;
    import inst_mem_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_fault;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    always #5 clock = ~clock;

    inst_fetch_mem #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_valid;
    logic [31:0] m_instr;
    bit          m_fault;
    logic [32:0] got [$];

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_fault = 0;
        m_instr = 32'h00000013;
`ifdef INST_FETCH_MEM_BOOTROM_EN
        for (int i = 0; i < DEPTH; i++) m_mem[i] = (i < 6) ? boot_word(i) : 32'h0;
`endif
    endtask

    // Called with inputs already driven, shortly after a falling edge
    task automatic step();
        bit          rdy;
        bit          acc;
        bit          f;
        logic [31:0] ins;
        #1;
        rdy = !reset && !flush && (!m_valid || rsp_ready);
        chk("req_ready", 33'(req_ready), 33'(rdy));
        chk("rsp_valid", 33'(rsp_valid), 33'(m_valid && !reset));
        if (reset) begin
            chk("reset_instr", 33'(rsp_instr), 33'h13);
            chk("reset_fault", 33'(rsp_fault), 33'h0);
        end else if (m_valid) begin
            chk("rsp_instr", 33'(rsp_instr), 33'(m_instr));
            chk("rsp_fault", 33'(rsp_fault), 33'(m_fault));
        end
        if (!reset && rsp_valid && rsp_ready) got.push_back({rsp_fault, rsp_instr});
        if (reset) begin
            model_reset();
        end else begin
            acc = req_valid && rdy;
            f   = addr_bad(req_addr);
            ins = f ? 32'h00000013 : m_mem[int'(req_addr >> 2)];
            if (flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1;
                m_instr = ins;
                m_fault = f;
            end else if (rsp_ready) m_valid = 0;
            if (wr_en && !addr_bad(wr_addr))
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) m_mem[int'(wr_addr >> 2)][8*b +: 8] = wr_data[8*b +: 8];
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic cyc(input bit rv, input logic [31:0] ra, input bit rr, input bit fl);
        req_valid = rv;
        req_addr  = ra;
        rsp_ready = rr;
        flush     = fl;
        wr_en     = 0;
        step();
    endtask

    task automatic wr_cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 0;
        rsp_ready = 1;
        flush     = 0;
        wr_en     = 1;
        wr_addr   = a;
        wr_data   = d;
        wr_strb   = s;
        step();
        wr_en = 0;
    endtask

    task automatic expect_got(input string name, input logic [32:0] exp);
        if (got.size() == 0) chk(name, 33'h1_FFFF_FFFF, exp);
        else chk(name, got.pop_front(), exp);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        if (r == 6) return {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        if (r == 7) return 32'h100;
        if (r == 8) return $urandom;
        return 32'hFC;
    endfunction

    initial begin
        reset = 1; req_valid = 0; req_addr = 0; rsp_ready = 0; flush = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        model_reset();
        @(negedge clock);
        // Reset state; a write attempted in reset must be ignored
        wr_en = 1; wr_addr = 32'h0; wr_data = 32'hBAD0BAD0; wr_strb = 4'hF; req_valid = 1;
        step();
        wr_en = 0; req_valid = 0;
        step();
        step();
        reset = 0;

`ifndef INST_FETCH_MEM_BOOTROM_EN
        for (int i = 0; i < DEPTH; i++)
            wr_cyc(32'(i * 4), (i < 6) ? boot_word(i) : $urandom, 4'hF);
`endif

        // Back-to-back boot fetches
        got.delete();
        for (int i = 0; i < 6; i++) cyc(1, 32'(i * 4), 1, 0);
        cyc(0, 0, 1, 0);
        expect_got("boot0", {1'b0, 32'h00940333});
        expect_got("boot1", {1'b0, 32'h412983b3});
        expect_got("boot2", {1'b0, 32'h00f768b3});
        expect_got("boot3", {1'b0, 32'h00d67fb3});
        expect_got("boot4", {1'b0, 32'h017b4e33});
        expect_got("boot5", {1'b0, 32'h01bdaf33});

        // Byte-strobe write over word 2
        got.delete();
        wr_cyc(32'h8, 32'hDEADBEEF, 4'b0101);
        cyc(1, 32'h8, 1, 0);
        cyc(0, 0, 1, 0);
        expect_got("strobe", {1'b0, 32'h00AD68EF});

        // Misaligned and one-past-end faults
        got.delete();
        cyc(1, 32'h2, 1, 0);
        cyc(1, 32'h100, 1, 0);
        cyc(0, 0, 1, 0);
        expect_got("fault_misalign", {1'b1, 32'h00000013});
        expect_got("fault_range", {1'b1, 32'h00000013});

        // Backpressure for three cycles
        got.delete();
        cyc(1, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h4, 0, 0);
        cyc(1, 32'h4, 1, 0);
        cyc(0, 0, 1, 0);
        expect_got("bp_first", {1'b0, 32'h00940333});
        expect_got("bp_second", {1'b0, 32'h412983b3});

        // Flush with a pending response and a simultaneous request
        got.delete();
        cyc(1, 32'h10, 0, 0);
        cyc(1, 32'h0, 0, 1);
        #1;
        chk("flush_drop", 33'(rsp_valid), 33'h0);
        cyc(0, 0, 1, 0);
        chk("flush_no_rsp", 33'(got.size()), 33'h0);

        // Same-cycle fetch and write to word 1 reads the old word
        got.delete();
        req_valid = 1; req_addr = 32'h4; rsp_ready = 1; flush = 0;
        wr_en = 1; wr_addr = 32'h4; wr_data = 32'h11111111; wr_strb = 4'hF;
        step();
        wr_en = 0;
        cyc(1, 32'h4, 1, 0);
        cyc(0, 0, 1, 0);
        expect_got("rdfirst_old", {1'b0, 32'h412983b3});
        expect_got("rdfirst_new", {1'b0, 32'h11111111});

        // Reset mid-operation drops the accepted request
        got.delete();
        cyc(1, 32'h0, 0, 0);
        reset = 1;
        cyc(1, 32'h8, 1, 0);
        reset = 0;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("reset_drop", 33'(got.size()), 33'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            req_valid = $urandom_range(0, 3) != 0;
            req_addr  = rand_addr();
            rsp_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 9) == 0;
            wr_en     = $urandom_range(0, 4) == 0;
            wr_addr   = rand_addr();
            wr_data   = $urandom;
            wr_strb   = 4'($urandom_range(0, 15));
            step();
        end
        reset = 0;
        cyc(0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
